fetch_pc_unit: RTL
==================

# fetch_pc_unit

Instruction-fetch front end for the multi-cycle CPU. Holds the program counter and the instruction register and computes the next PC from the `PCSrc` selector. Drives the instruction-memory address and slices the held instruction into the opcode and operand fields consumed by `controlUnit` and the register file. `controlUnit` pulses `PCWre`/`IRWre` in its IF state; this block is the stage directly upstream of it.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: address of the first instruction fetched after reset.
- `HALT_OP`, default 6'b111111: opcode that halts fetch.

Ports:
- `clk`  in  1: single clock, rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `PCWre`  in  1: PC write enable (from `controlUnit`).
- `IRWre`  in  1: IR write enable (from `controlUnit`).
- `PCSrc`  in  2: next-PC select. 00 = PC+4, 01 = branch, 10 = register, 11 = jump.
- `rs_data`  in  32: register-file rs read data, used as the target for `PCSrc`=10.
- `ExtSel`  in  1: immediate extension. 1 = sign, 0 = zero.
- `imem_addr`  out  32: instruction-memory address (= `next_pc`).
- `imem_rdata`  in  32: instruction-memory read data. Combinational read of `imem_addr`.
- `pc`  out  32: address of the instruction currently in IR.
- `next_pc`  out  32: combinational next-PC value.
- `opcode`  out  6: IR[31:26].
- `rs`  out  5: IR[25:21].
- `rt`  out  5: IR[20:16].
- `rd`  out  5: IR[15:11].
- `imm_ext`  out  32: IR[15:0], extended per `ExtSel`.
- `halted`  out  1: sticky halt flag.
- `fetch_count`  out  32: number of instructions loaded into IR since reset.

## Operation
- Registers: `pc`, `ir`, `started`, `halted`, `fetch_count`.
- Reset values (asynchronous, while `Reset`=0): `pc`=0, `ir`=0, `started`=0, `halted`=0, `fetch_count`=0.
- `pc4` = `pc` + 4. All address arithmetic is 32-bit, modulo 2^32; overflow wraps silently.
- `next_pc` selection:
  - `started`=0: `RESET_PC`, regardless of `PCSrc`.
  - `PCSrc` 00: `pc4`.
  - `PCSrc` 01: `pc4` + (`imm_ext` << 2). Branch targets always use the sign-extended immediate, independent of `ExtSel`.
  - `PCSrc` 10: `rs_data` with bits [1:0] forced to 00.
  - `PCSrc` 11: {`pc4`[31:28], `ir`[25:0], 2'b00}.
- PC update: on a rising edge with `PCWre`=1 and `halted`=0, `pc` <= `next_pc`, `started` <= 1.
- IR update: on a rising edge with `IRWre`=1 and `halted`=0, `ir` <= `imem_rdata` and `fetch_count` increments. Because `imem_addr` = `next_pc`, `pc` and `ir` stay paired: `pc` is always the address of the instruction in `ir`.
- `IRWre` without `PCWre`: the IR reloads from `next_pc` while `pc` is unchanged. This is legal but breaks the pairing. The bench flags it as a protocol warning, not an error.
- Halt: when `opcode` == `HALT_OP` and `started`=1, `halted` <= 1 on the next edge. Once set, `pc`, `ir` and `fetch_count` freeze until `Reset`.
- `fetch_count` saturates at 32'hFFFF_FFFF.

## Timing
- `next_pc`, `imem_addr`, the decoded fields and `imm_ext` are combinational from the registers and inputs, with zero latency.
- `pc`, `ir` and `halted` change only at a rising edge, or asynchronously on reset.
- Fetch latency is one edge: the instruction at `next_pc` is visible on `opcode` immediately after the IF edge.
- Branch timing: `PCSrc` is sampled in the IF cycle, and `controlUnit` derives it from the previous instruction still held in `ir`.
- Simultaneous halt detection and `PCWre`: the halt instruction is already in `ir`. `halted` sets on the first edge after it is loaded, and that same edge's `PCWre` is honoured. A halt-opcode instruction still counts as fetched.
- Reset asserted mid-operation clears all state immediately. After reset release, the first `PCWre` edge fetches `RESET_PC`.

## Structure
- Shared CPU package, reused by `controlUnit` and the ALU stage:
  - `PCSrc` encoding constants (`PCSRC_SEQ`, `PCSRC_BR`, `PCSRC_REG`, `PCSRC_J`).
  - `HALT_OP`.
  - Instruction field bit positions.
- One natural sub-module, `next_pc_mux`: purely combinational next-PC and jump/branch target generation.

## Test plan
- Reset, then a `PCWre`+`IRWre` pulse with `RESET_PC`=0 and imem[0]=32'h0000_0000 → `pc`=0, `ir`=0, `fetch_count`=1, `started`=1.
- Sequential path: `pc`=32'h10, `PCSrc`=00, IF pulse → `imem_addr` and new `pc` = 32'h14.
- Branch: `pc`=32'h20, `ir`[15:0]=16'hFFFE, `PCSrc`=01, `ExtSel`=0 → `next_pc`=32'h1C. The branch still sign-extends while `imm_ext` reads 32'h0000_FFFE.
- Jump: `pc`=32'hF000_0040, `ir`[25:0]=26'h0000010, `PCSrc`=11 → `next_pc`=32'hF000_0040. Register jump with `rs_data`=32'h0000_0123, `PCSrc`=10 → `next_pc`=32'h0000_0120.
- Halt: load 32'hFC00_0000 → `halted`=1 on the next edge. Further IF pulses leave `pc`, `ir` and `fetch_count` unchanged.
- Reset mid-run: pull `Reset` low between clock edges → all outputs 0 at once, with no clock edge. After release, the first `PCWre` pulse fetches `RESET_PC` even though `PCSrc`=11.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU definitions: next-PC select encoding, halt opcode and instruction
// field positions used by the fetch stage, controlUnit and the ALU stage.
package fetch_pc_unit_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_REG = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 11;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;
  localparam int JIDX_HI = 25;
  localparam int JIDX_LO = 0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_mux.sv
// Combinational next-PC selection: sequential, branch, register and jump
// targets, with RESET_PC forced until the first PC write after reset.
module next_pc_mux
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_started,
  input  logic [1:0]  i_pcsrc,
  input  logic [31:0] i_pc,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_jidx,
  input  logic [31:0] i_rs_data,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_reg_tgt;
  logic [31:0] w_j_tgt;

  assign w_pc4     = i_pc + 32'd4;
  // Branch offsets are always signed, whatever ExtSel says for the ALU path.
  assign w_br_tgt  = w_pc4 + (sext16(i_imm) << 2);
  assign w_reg_tgt = i_rs_data & 32'hFFFF_FFFC;
  assign w_j_tgt   = {w_pc4[31:28], i_jidx, 2'b00};

  always_comb begin
    o_next_pc = w_pc4;
    if (!i_started) begin
      o_next_pc = RESET_PC;
    end else begin
      case (i_pcsrc)
        PCSRC_SEQ: o_next_pc = w_pc4;
        PCSRC_BR:  o_next_pc = w_br_tgt;
        PCSRC_REG: o_next_pc = w_reg_tgt;
        PCSRC_J:   o_next_pc = w_j_tgt;
        default:   o_next_pc = w_pc4;
      endcase
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC and IR registers, next-PC generation,
// instruction field decode, sticky halt and a saturating fetch counter.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = OP_HALT
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic        IRWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] rs_data,
  input  logic        ExtSel,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_ext,
  output logic        halted,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_started;
  logic        r_halted;
  logic [31:0] r_fetch_count;

  logic [31:0] w_next_pc;
  logic [5:0]  w_opcode;
  logic [15:0] w_imm;
  logic        w_pc_we;
  logic        w_ir_we;

  assign w_opcode = r_ir[OP_HI:OP_LO];
  assign w_imm    = r_ir[IMM_HI:IMM_LO];
  assign w_pc_we  = PCWre && !r_halted;
  assign w_ir_we  = IRWre && !r_halted;

  next_pc_mux #(
    .RESET_PC (RESET_PC)
  ) u_next_pc_mux (
    .i_started (r_started),
    .i_pcsrc   (PCSrc),
    .i_pc      (r_pc),
    .i_imm     (w_imm),
    .i_jidx    (r_ir[JIDX_HI:JIDX_LO]),
    .i_rs_data (rs_data),
    .o_next_pc (w_next_pc)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_pc      <= 32'h0000_0000;
      r_started <= 1'b0;
    end else if (w_pc_we) begin
      r_pc      <= w_next_pc;
      r_started <= 1'b1;
    end
  end

  // imem reads next_pc, so a paired PCWre/IRWre keeps pc naming the IR's address.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_ir          <= 32'h0000_0000;
      r_fetch_count <= 32'h0000_0000;
    end else if (w_ir_we) begin
      r_ir <= imem_rdata;
      if (r_fetch_count != 32'hFFFF_FFFF) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_halted <= 1'b0;
    end else if (r_started && (w_opcode == HALT_OP)) begin
      r_halted <= 1'b1;
    end
  end

  assign imem_addr   = w_next_pc;
  assign next_pc     = w_next_pc;
  assign pc          = r_pc;
  assign opcode      = w_opcode;
  assign rs          = r_ir[RS_HI:RS_LO];
  assign rt          = r_ir[RT_HI:RT_LO];
  assign rd          = r_ir[RD_HI:RD_LO];
  assign imm_ext     = ExtSel ? sext16(w_imm) : zext16(w_imm);
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule
